// File: rtl/hard_drive_controller.sv
// Track/sector word store with modelled seek (|dtrack|*SEEK_CYCLES_PER_TRACK) and ACCESS_CYCLES access time;
// done pulses D+ACCESS_CYCLES+1 cycles after accept (1 for a bad address); requests while ready=0 are dropped.
module hard_drive_controller #(
  parameter int DATA_WIDTH            = 32,
  parameter int TRACK_BITS            = 7,
  parameter int SECTOR_BITS           = 14,
  parameter int NUM_TRACKS            = 8,
  parameter int SECTORS_PER_TRACK     = 16,
  parameter int SEEK_CYCLES_PER_TRACK = 1,
  parameter int ACCESS_CYCLES         = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   request,
  input  logic                   write_enable,
  input  logic [TRACK_BITS-1:0]  track,
  input  logic [SECTOR_BITS-1:0] sector,
  input  logic [DATA_WIDTH-1:0]  data_write,
  output logic                   ready,
  output logic                   done,
  output logic                   error,
  output logic [DATA_WIDTH-1:0]  data_read,
  output logic [TRACK_BITS-1:0]  head_track
);

  localparam int DEPTH = NUM_TRACKS * SECTORS_PER_TRACK;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SEEK, ACCESS, DONE} state_t;

  state_t state, state_nxt;

  logic                  lat_we;
  logic [TRACK_BITS-1:0] lat_track;
  logic [IDX_W-1:0]      lat_idx;
  logic [DATA_WIDTH-1:0] lat_data;
  logic                  err_q;
  logic [31:0]           seek_cnt;
  logic [31:0]           acc_cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  out_of_range;
  logic [TRACK_BITS-1:0] track_diff;
  logic [31:0]           seek_dist;
  logic [IDX_W-1:0]      lin_idx;
  logic                  seek_last;
  logic                  access_last;

  assign accept       = (state == IDLE) && request;
  assign out_of_range = (32'(track) >= 32'(NUM_TRACKS)) ||
                        (32'(sector) >= 32'(SECTORS_PER_TRACK));
  // Unsigned distance; never wraps around the platter.
  assign track_diff   = (track >= head_track) ? (track - head_track) : (head_track - track);
  assign seek_dist    = 32'(track_diff) * 32'(SEEK_CYCLES_PER_TRACK);
  assign lin_idx      = IDX_W'(IDX_W'(track) * IDX_W'(SECTORS_PER_TRACK) + IDX_W'(sector));
  assign seek_last    = (seek_cnt == 32'd1);
  assign access_last  = (acc_cnt == 32'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (request) begin
          if (out_of_range)          state_nxt = DONE;
          else if (seek_dist != '0) state_nxt = SEEK;
          else                       state_nxt = ACCESS;
        end
      end
      SEEK:    if (seek_last)   state_nxt = ACCESS;
      ACCESS:  if (access_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
    error = err_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_we     <= 1'b0;
      lat_track  <= '0;
      lat_idx    <= '0;
      lat_data   <= '0;
      err_q      <= 1'b0;
      seek_cnt   <= '0;
      acc_cnt    <= '0;
      data_read  <= '0;
      head_track <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= write_enable;
            lat_track <= track;
            lat_idx   <= lin_idx;
            lat_data  <= data_write;
            err_q     <= out_of_range;
            seek_cnt  <= out_of_range ? '0 : seek_dist;
            acc_cnt   <= 32'(ACCESS_CYCLES - 1);
          end
        end
        SEEK: begin
          seek_cnt <= seek_cnt - 32'd1;
          if (seek_last) head_track <= lat_track;
        end
        ACCESS: begin
          if (!access_last) acc_cnt <= acc_cnt - 32'd1;
          else if (!lat_we) data_read <= mem[lat_idx];
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; an async reset before the final ACCESS edge drops the write.
  always_ff @(posedge clock) begin
    if ((state == ACCESS) && access_last && lat_we)
      mem[lat_idx] <= lat_data;
  end

endmodule

// File: tb/tb_hard_drive_controller.sv
// Directed bench for hard_drive_controller with default parameters.
module tb_hard_drive_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        request;
  logic        write_enable;
  logic [6:0]  track;
  logic [13:0] sector;
  logic [31:0] data_write;
  logic        ready;
  logic        done;
  logic        error;
  logic [31:0] data_read;
  logic [6:0]  head_track;

  int pass_cnt = 0;
  int total_cnt = 0;

  hard_drive_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .request      (request),
    .write_enable (write_enable),
    .track        (track),
    .sector       (sector),
    .data_write   (data_write),
    .ready        (ready),
    .done         (done),
    .error        (error),
    .data_read    (data_read),
    .head_track   (head_track)
  );

  always #5 clock = ~clock;

  // Runs one request; n = cycles from the accepting edge until done is seen (-1 on timeout).
  task automatic do_op(input logic we, input logic [6:0] trk, input logic [13:0] sec,
                       input logic [31:0] dat, output int n, output logic err_o,
                       output logic done_after, output logic ready_after);
    int w = 0;
    while (!ready && w < 50) begin
      @(posedge clock); #1;
      w++;
    end
    write_enable = we;
    track        = trk;
    sector       = sec;
    data_write   = dat;
    request      = 1'b1;
    @(posedge clock); #1;
    request = 1'b0;
    n = -1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        n = k;
        break;
      end
      @(posedge clock); #1;
    end
    err_o = error;
    @(posedge clock); #1;
    done_after  = done;
    ready_after = ready;
  endtask

  task automatic test_reset();
    #12 reset_n = 1'b0;
    #1;
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL reset_error got=%b exp=0", error); else pass_cnt++;
    total_cnt++; if (data_read !== 32'h0) $display("FAIL reset_data got=%h exp=0", data_read); else pass_cnt++;
    total_cnt++; if (head_track !== 7'd0) $display("FAIL reset_head got=%0d exp=0", head_track); else pass_cnt++;
    #9 reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_write_default();
    int n; logic e, da, ra;
    do_op(1'b1, 7'd3, 14'd5, 32'hDEADBEEF, n, e, da, ra);
    total_cnt++; if (n !== 5) $display("FAIL wr_latency got=%0d exp=5", n); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL wr_error got=%b exp=0", e); else pass_cnt++;
    total_cnt++; if (head_track !== 7'd3) $display("FAIL wr_head got=%0d exp=3", head_track); else pass_cnt++;
    total_cnt++; if (data_read !== 32'h0) $display("FAIL wr_data_read got=%h exp=0", data_read); else pass_cnt++;
    total_cnt++; if (da !== 1'b0) $display("FAIL wr_done_pulse got=%b exp=0", da); else pass_cnt++;
    total_cnt++; if (ra !== 1'b1) $display("FAIL wr_ready_after got=%b exp=1", ra); else pass_cnt++;
  endtask

  task automatic test_read_back();
    int n; logic e, da, ra;
    do_op(1'b0, 7'd3, 14'd5, 32'h0, n, e, da, ra);
    total_cnt++; if (n !== 2) $display("FAIL rd_latency got=%0d exp=2", n); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL rd_error got=%b exp=0", e); else pass_cnt++;
    total_cnt++; if (data_read !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", data_read); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    int n; logic e, da, ra;
    // Known values at (4,0), where an aliased (3,16) would land, and at (3,0).
    do_op(1'b1, 7'd4, 14'd0, 32'h44444444, n, e, da, ra);
    total_cnt++; if (n !== 3) $display("FAIL pre_wr40_latency got=%0d exp=3", n); else pass_cnt++;
    do_op(1'b1, 7'd3, 14'd0, 32'h33333333, n, e, da, ra);
    total_cnt++; if (n !== 3) $display("FAIL pre_wr30_latency got=%0d exp=3", n); else pass_cnt++;

    do_op(1'b1, 7'd3, 14'd16, 32'h12345678, n, e, da, ra);
    total_cnt++; if (n !== 0) $display("FAIL oor_sec_latency got=%0d exp=0", n); else pass_cnt++;
    total_cnt++; if (e !== 1'b1) $display("FAIL oor_sec_error got=%b exp=1", e); else pass_cnt++;
    total_cnt++; if (head_track !== 7'd3) $display("FAIL oor_sec_head got=%0d exp=3", head_track); else pass_cnt++;
    total_cnt++; if (data_read !== 32'hDEADBEEF) $display("FAIL oor_sec_data got=%h exp=deadbeef", data_read); else pass_cnt++;
    total_cnt++; if (ra !== 1'b1) $display("FAIL oor_sec_ready_after got=%b exp=1", ra); else pass_cnt++;

    do_op(1'b0, 7'd8, 14'd0, 32'h0, n, e, da, ra);
    total_cnt++; if (n !== 0) $display("FAIL oor_trk_latency got=%0d exp=0", n); else pass_cnt++;
    total_cnt++; if (e !== 1'b1) $display("FAIL oor_trk_error got=%b exp=1", e); else pass_cnt++;
    total_cnt++; if (head_track !== 7'd3) $display("FAIL oor_trk_head got=%0d exp=3", head_track); else pass_cnt++;

    do_op(1'b0, 7'd3, 14'd0, 32'h0, n, e, da, ra);
    total_cnt++; if (e !== 1'b0) $display("FAIL rd30_error got=%b exp=0", e); else pass_cnt++;
    total_cnt++; if (data_read !== 32'h33333333) $display("FAIL rd30_data got=%h exp=33333333", data_read); else pass_cnt++;
    do_op(1'b0, 7'd3, 14'd5, 32'h0, n, e, da, ra);
    total_cnt++; if (data_read !== 32'hDEADBEEF) $display("FAIL rd35_data got=%h exp=deadbeef", data_read); else pass_cnt++;
    do_op(1'b0, 7'd4, 14'd0, 32'h0, n, e, da, ra);
    total_cnt++; if (n !== 3) $display("FAIL rd40_latency got=%0d exp=3", n); else pass_cnt++;
    total_cnt++; if (data_read !== 32'h44444444) $display("FAIL rd40_data got=%h exp=44444444", data_read); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int n; logic e, da, ra;
    int done_cnt = 0;
    int first = -1;
    logic ready_early = 1'b0;
    // Head at 4: write (7,0) seeks 3 tracks.
    write_enable = 1'b1; track = 7'd7; sector = 14'd0; data_write = 32'h77777777;
    request = 1'b1;
    @(posedge clock); #1;
    write_enable = 1'b0; track = 7'd1; sector = 14'd1; data_write = 32'h0;
    total_cnt++; if (ready !== 1'b0) $display("FAIL busy_ready_in_seek got=%b exp=0", ready); else pass_cnt++;
    @(posedge clock); #1;
    request = 1'b0;
    for (int k = 1; k < 15; k++) begin
      if (done) begin
        done_cnt++;
        if (first < 0) first = k;
      end
      if (first < 0 && ready) ready_early = 1'b1;
      @(posedge clock); #1;
    end
    total_cnt++; if (done_cnt !== 1) $display("FAIL busy_done_count got=%0d exp=1", done_cnt); else pass_cnt++;
    total_cnt++; if (first !== 5) $display("FAIL busy_done_cycle got=%0d exp=5", first); else pass_cnt++;
    total_cnt++; if (ready_early !== 1'b0) $display("FAIL busy_ready_early got=%b exp=0", ready_early); else pass_cnt++;
    total_cnt++; if (head_track !== 7'd7) $display("FAIL busy_head got=%0d exp=7", head_track); else pass_cnt++;
    do_op(1'b0, 7'd7, 14'd0, 32'h0, n, e, da, ra);
    total_cnt++; if (data_read !== 32'h77777777) $display("FAIL busy_rd70 got=%h exp=77777777", data_read); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    write_enable = 1'b0; track = 7'd7; sector = 14'd0; data_write = 32'h0;
    request = 1'b1;
    @(posedge clock); #1;
    for (int k = 0; k < 12; k++) begin
      if (done) done_at.push_back(k);
      if (k == 7) request = 1'b0;
      @(posedge clock); #1;
    end
    total_cnt++; if (done_at.size() !== 2) $display("FAIL b2b_count got=%0d exp=2", done_at.size()); else pass_cnt++;
    if (done_at.size() >= 2) begin
      total_cnt++; if (done_at[0] !== 2) $display("FAIL b2b_first got=%0d exp=2", done_at[0]); else pass_cnt++;
      total_cnt++; if (done_at[1] !== 6) $display("FAIL b2b_second got=%0d exp=6", done_at[1]); else pass_cnt++;
    end
    total_cnt++; if (ready !== 1'b1) $display("FAIL b2b_idle got=%b exp=1", ready); else pass_cnt++;
  endtask

  task automatic test_reset_in_seek();
    int n; logic e, da, ra;
    do_op(1'b1, 7'd6, 14'd2, 32'h0, n, e, da, ra);
    total_cnt++; if (n !== 3) $display("FAIL rs_prewrite_latency got=%0d exp=3", n); else pass_cnt++;
    // Pull head back to 7 so the next (6,2) write has a seek phase.
    do_op(1'b0, 7'd7, 14'd0, 32'h0, n, e, da, ra);
    write_enable = 1'b1; track = 7'd6; sector = 14'd2; data_write = 32'hCAFE0000;
    request = 1'b1;
    @(posedge clock); #1;
    request = 1'b0;
    total_cnt++; if (ready !== 1'b0) $display("FAIL rs_busy got=%b exp=0", ready); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (ready !== 1'b1) $display("FAIL rs_ready got=%b exp=1", ready); else pass_cnt++;
    total_cnt++; if (head_track !== 7'd0) $display("FAIL rs_head got=%0d exp=0", head_track); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rs_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++; if (data_read !== 32'h0) $display("FAIL rs_data got=%h exp=0", data_read); else pass_cnt++;
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    do_op(1'b0, 7'd6, 14'd2, 32'h0, n, e, da, ra);
    total_cnt++; if (n !== 8) $display("FAIL rs_read_latency got=%0d exp=8", n); else pass_cnt++;
    total_cnt++; if (data_read !== 32'h0) $display("FAIL rs_read_data got=%h exp=0", data_read); else pass_cnt++;
    total_cnt++; if (head_track !== 7'd6) $display("FAIL rs_read_head got=%0d exp=6", head_track); else pass_cnt++;
  endtask

  initial begin
    reset_n      = 1'b1;
    request      = 1'b0;
    write_enable = 1'b0;
    track        = '0;
    sector       = '0;
    data_write   = '0;
    test_reset();
    test_write_default();
    test_read_back();
    test_out_of_range();
    test_busy_ignore();
    test_back_to_back();
    test_reset_in_seek();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
